commit_trace_tx: RTL

- Producer side of the commit-trace interface: collects retired-instruction records (pc, nextpc, inst) from the core's writeback stage and emits them one per cycle on the dpi_valid/pc/nextpc/inst port consumed by the simulation DPI reporter.
- Buffers records in a small FIFO so difftest can pause the trace without stalling writeback.
- Checks control-flow continuity and counts committed instructions.

---
 rtl/commit_trace_tx.sv | 102 ++++++++++
 1 files changed

// File: rtl/commit_trace_tx.sv
// Commit-trace producer: buffers retired records from writeback
// and emits them one per cycle toward the DPI trace reporter.
module commit_trace_tx #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_nextpc,
    input  logic [31:0] in_inst,
    input  logic        out_hold,
    output logic        dpi_valid,
    output logic [31:0] pc,
    output logic [31:0] nextpc,
    output logic [31:0] inst,
    output logic [63:0] commit_cnt,
    output logic        order_err,
    output logic [31:0] order_err_pc
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [95:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic          first;
    logic          push;
    logic          pop;
    logic [31:0]   head_pc;
    logic [31:0]   head_nextpc;
    logic [31:0]   head_inst;

    assign in_ready    = (count != FULL);
    assign push        = in_valid && in_ready;
    assign pop         = !out_hold && (count != '0);
    assign head_pc     = mem[head][95:64];
    assign head_nextpc = mem[head][63:32];
    assign head_inst   = mem[head][31:0];

    // Record storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail] <= {in_pc, in_nextpc, in_inst};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Emit stage: output registers, commit counter, continuity check.
    // The nextpc register doubles as the last emitted nextpc.
    always_ff @(posedge clock) begin
        if (reset) begin
            dpi_valid    <= 1'b0;
            pc           <= '0;
            nextpc       <= '0;
            inst         <= '0;
            commit_cnt   <= '0;
            order_err    <= 1'b0;
            order_err_pc <= '0;
            first        <= 1'b1;
        end else begin
            dpi_valid <= pop;
            if (pop) begin
                pc         <= head_pc;
                nextpc     <= head_nextpc;
                inst       <= head_inst;
                commit_cnt <= commit_cnt + 64'd1;
                first      <= 1'b0;
                if (!first && (head_pc != nextpc)) begin
                    order_err <= 1'b1;
                    if (!order_err) begin
                        order_err_pc <= head_pc;
                    end
                end
            end
        end
    end

endmodule
